// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    // Width of a counter that must reach w, the bit count of an operation.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_w(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = M - N, LSB first, one bit per clock.
// Optional signed-overflow output OVF enabled by SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] N,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int unsigned CW = (WIDTH == WIDTH_DEF) ? CNT_W : cnt_w(WIDTH);

    sub_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_m, w_m_nxt;
    logic [WIDTH-1:0] r_n, w_n_nxt;
    logic [WIDTH-1:0] r_diff, w_diff_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_borrow, w_borrow_nxt;
    logic             r_borrow_out, w_borrow_out_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             r_ovf, w_ovf_nxt;
`endif

    logic             w_d;
    logic             w_bout;

    // The single subtractor cell shared by every bit position.
    full_subtractor u_cell (
        .a    (r_m[0]),
        .b    (r_n[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_m          <= '0;
            r_n          <= '0;
            r_diff       <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_ovf        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_m          <= w_m_nxt;
            r_n          <= w_n_nxt;
            r_diff       <= w_diff_nxt;
            r_cnt        <= w_cnt_nxt;
            r_borrow     <= w_borrow_nxt;
            r_borrow_out <= w_borrow_out_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_ovf        <= w_ovf_nxt;
`endif
        end
    end

    // Next-state and next-register values; done is a one-cycle pulse by default.
    always_comb begin
        w_state_nxt      = r_state;
        w_m_nxt          = r_m;
        w_n_nxt          = r_n;
        w_diff_nxt       = r_diff;
        w_cnt_nxt        = r_cnt;
        w_borrow_nxt     = r_borrow;
        w_borrow_out_nxt = r_borrow_out;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        w_ovf_nxt        = r_ovf;
`endif

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_m_nxt      = M;
                    w_n_nxt      = N;
                    w_borrow_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = RUN;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end

            RUN: begin
                // Result bits enter from the MSB so bit 0 lands at DIFF[0] last.
                w_diff_nxt   = {w_d, r_diff[WIDTH-1:1]};
                w_m_nxt      = {1'b0, r_m[WIDTH-1:1]};
                w_n_nxt      = {1'b0, r_n[WIDTH-1:1]};
                w_borrow_nxt = w_bout;
                w_cnt_nxt    = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_borrow_out_nxt = w_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    // Borrow into the MSB differs from borrow out: signed overflow.
                    w_ovf_nxt        = r_borrow ^ w_bout;
`endif
                    w_busy_nxt       = 1'b0;
                    w_done_nxt       = 1'b1;
                    w_state_nxt      = DONE;
                end
            end

            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign DIFF   = r_diff;
    assign BORROW = r_borrow_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign OVF    = r_ovf;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors, queue-based checking.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        int           cyc;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] m;
        logic [W-1:0] n;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] M;
    logic [W-1:0] N;
    logic         busy;
    logic         done;
    logic [W-1:0] DIFF;
    logic         BORROW;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         OVF;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .M      (M),
        .N      (N),
        .busy   (busy),
        .done   (done),
        .DIFF   (DIFF),
        .BORROW (BORROW)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .OVF    (OVF)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected none pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_latency", 32'(cyc), 32'(e.cyc));
                check("diff", 32'(DIFF), 32'(e.diff));
                check("borrow", 32'(BORROW), 32'(e.borrow));
                check("busy_at_done", 32'(busy), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                check("ovf", 32'(OVF), 32'(e.ovf));
`endif
            end
        end
    end

    // Start one operation from IDLE/DONE; the accepting edge is the next posedge.
    task automatic issue(input vec_t v);
        exp_t e;
        @(negedge clk);
        M     = v.m;
        N     = v.n;
        start = 1'b1;
        e.diff   = v.diff;
        e.borrow = v.borrow;
        e.ovf    = v.ovf;
        e.cyc    = cyc + 1 + 8;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Bounded wait for the scoreboard to drain.
    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{m: 8'd100, n: 8'd37,  diff: 8'd63,  borrow: 1'b0, ovf: 1'b0};
        vecs[1] = '{m: 8'd5,   n: 8'd10,  diff: 8'd251, borrow: 1'b1, ovf: 1'b0};
        vecs[2] = '{m: 8'hFF,  n: 8'hFF,  diff: 8'h00,  borrow: 1'b0, ovf: 1'b0};
        vecs[3] = '{m: 8'h00,  n: 8'h01,  diff: 8'hFF,  borrow: 1'b1, ovf: 1'b0};
        vecs[4] = '{m: 8'h80,  n: 8'h01,  diff: 8'h7F,  borrow: 1'b0, ovf: 1'b1};
        vecs[5] = '{m: 8'h7F,  n: 8'hFF,  diff: 8'h80,  borrow: 1'b1, ovf: 1'b1};
        vecs[6] = '{m: 8'hC8,  n: 8'h0A,  diff: 8'hBE,  borrow: 1'b0, ovf: 1'b0};
        vecs[7] = '{m: 8'h3C,  n: 8'h3C,  diff: 8'h00,  borrow: 1'b0, ovf: 1'b0};
        vecs[8] = '{m: 8'h01,  n: 8'h80,  diff: 8'h81,  borrow: 1'b1, ovf: 1'b1};
        vecs[9] = '{m: 8'hAA,  n: 8'h55,  diff: 8'h55,  borrow: 1'b0, ovf: 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        M     = 8'hA5;
        N     = 8'h5A;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(DIFF), 32'd0);
        check("rst_borrow", 32'(BORROW), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("rst_ovf", 32'(OVF), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, one at a time.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i]);
            drain();
        end

        // start pulsed during RUN with different operands must be ignored.
        issue(vecs[0]);
        repeat (2) @(negedge clk);
        M     = 8'h01;
        N     = 8'hFE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held high through DONE: back-to-back results spaced 9 cycles.
        begin
            exp_t e;
            @(negedge clk);
            M     = vecs[1].m;
            N     = vecs[1].n;
            start = 1'b1;
            e = '{diff: vecs[1].diff, borrow: vecs[1].borrow, ovf: vecs[1].ovf, cyc: cyc + 9};
            q.push_back(e);
            e = '{diff: vecs[5].diff, borrow: vecs[5].borrow, ovf: vecs[5].ovf, cyc: cyc + 18};
            q.push_back(e);
            @(negedge clk);
            M = vecs[5].m;
            N = vecs[5].n;
            repeat (8) @(negedge clk);
            check("b2b_done_first", 32'(done), 32'd1);
            @(negedge clk);
            start = 1'b0;
            check("b2b_busy_second", 32'(busy), 32'd1);
            drain();
        end

        // Asynchronous reset in the middle of an operation.
        issue(vecs[9]);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(DIFF), 32'd0);
        check("midrst_borrow", 32'(BORROW), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_done_busy", 32'(busy), 32'd0);
        issue(vecs[6]);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_subtractor
